// File: rtl/conv_strip_scheduler.sv
// conv_strip_scheduler: kernel load, strip launch and ordered result drain; optional watchdog via STRIP_TIMEOUT_EN
module conv_strip_scheduler #(
  parameter int NUM_STRIPS      = 8,
  parameter int STRIP_OUT_DEPTH = 5772,
  parameter int ADDR_W          = 13,
  parameter int DATA_W          = 23,
  parameter int RD_LAT          = 2,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         k_valid,
  input  logic [8:0]                   k_data,
  output logic                         k_ready,
  input  logic                         frame_start,
  output logic [80:0]                  kernel_flat,
  output logic                         kernel_read_complete,
  output logic                         strip_rst,
  output logic                         strip_start,
  input  logic [NUM_STRIPS-1:0]        strip_done,
  output logic [ADDR_W-1:0]            strip_addr,
  input  logic [NUM_STRIPS*DATA_W-1:0] strip_out_flat,
  output logic [DATA_W-1:0]            pix_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         pix_last,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         timeout_err
);
  localparam int SW = NUM_STRIPS > 1 ? $clog2(NUM_STRIPS) : 1;
  typedef enum logic [2:0] {IDLE, CLR, LAUNCH, WAIT_DONE, RD_ISSUE, RD_WAIT, RD_PRESENT, FINISH} state_t;
  state_t                state_q;
  logic [3:0]            kidx_q;
  logic [80:0]           kernel_q;
  logic                  krc_q;
  logic [NUM_STRIPS-1:0] done_seen_q;
  logic [NUM_STRIPS-1:0] done_seen_d;
  logic [SW-1:0]         sidx_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            wait_q;
  logic [DATA_W-1:0]     pix_q;
  logic                  last_addr;
  logic                  last_strip;
  logic                  to_hit;
  assign done_seen_d          = done_seen_q | strip_done;
  assign last_addr            = addr_q == ADDR_W'(STRIP_OUT_DEPTH - 1);
  assign last_strip           = sidx_q == SW'(NUM_STRIPS - 1);
  assign k_ready              = state_q == IDLE;
  assign busy                 = state_q != IDLE;
  assign strip_rst            = reset | (state_q == CLR);
  assign strip_start          = state_q == LAUNCH;
  assign pix_valid            = state_q == RD_PRESENT;
  assign pix_last             = pix_valid & last_addr & last_strip;
  assign frame_done           = state_q == FINISH;
  assign kernel_flat          = kernel_q;
  assign kernel_read_complete = krc_q;
  assign strip_addr           = addr_q;
  assign pix_data             = pix_q;
`ifdef STRIP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;
  logic          to_err_q;
  assign to_hit      = (state_q == WAIT_DONE) && (to_q == TW'(TIMEOUT_CYCLES - 1)) && !(&done_seen_d);
  assign timeout_err = to_err_q;
  // watchdog counts WAIT_DONE cycles; error is sticky until the next frame clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      to_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_q     <= state_q == WAIT_DONE ? to_q + 1'b1 : '0;
      to_err_q <= state_q == CLR ? 1'b0 : (to_err_q | to_hit);
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = TIMEOUT_CYCLES < 0;
`endif
  // frame controller: kernel capture in IDLE, launch, done collection and per-pixel read sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kidx_q      <= '0;
      kernel_q    <= '0;
      krc_q       <= 1'b0;
      done_seen_q <= '0;
      sidx_q      <= '0;
      addr_q      <= '0;
      wait_q      <= '0;
      pix_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (k_valid) begin
            kernel_q[kidx_q*9 +: 9] <= k_data;
            krc_q                   <= kidx_q == 4'd8;
            kidx_q                  <= kidx_q == 4'd8 ? 4'd0 : kidx_q + 4'd1;
          end else if (frame_start && krc_q) begin
            state_q <= CLR;
          end
        end
        CLR: state_q <= LAUNCH;
        LAUNCH: begin
          done_seen_q <= '0;
          state_q     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          done_seen_q <= done_seen_d;
          if (&done_seen_d) begin
            sidx_q  <= '0;
            addr_q  <= '0;
            state_q <= RD_ISSUE;
          end else if (to_hit) begin
            state_q <= FINISH;
          end
        end
        RD_ISSUE: begin
          wait_q  <= 3'(RD_LAT);
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          wait_q <= wait_q - 3'd1;
          if (wait_q == 3'd1) begin
            pix_q   <= strip_out_flat[sidx_q*DATA_W +: DATA_W];
            state_q <= RD_PRESENT;
          end
        end
        RD_PRESENT: begin
          if (pix_ready) begin
            if (last_addr) begin
              addr_q  <= '0;
              sidx_q  <= last_strip ? sidx_q : sidx_q + 1'b1;
              state_q <= last_strip ? FINISH : RD_ISSUE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= RD_ISSUE;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_strip_scheduler.sv
// tb_conv_strip_scheduler: directed checks of kernel load, frame drain, stall, reset abort and watchdog
module tb_conv_strip_scheduler;
  logic        clk = 0;
  logic        reset = 1;
  logic        k_valid = 0;
  logic [8:0]  k_data = '0;
  logic        k_ready;
  logic        frame_start = 0;
  logic [80:0] kernel_flat;
  logic        kernel_read_complete;
  logic        strip_rst;
  logic        strip_start;
  logic [1:0]  strip_done = '0;
  logic [12:0] strip_addr;
  logic [45:0] strip_out_flat;
  logic [22:0] pix_data;
  logic        pix_valid;
  logic        pix_ready = 1;
  logic        pix_last;
  logic        frame_done;
  logic        busy;
  logic        timeout_err;
  logic [12:0] p1 = '0;
  logic [12:0] p2 = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  kv [9] = '{9'h001, 9'h1FF, 9'h002, 9'h1FE, 9'h003, 9'h1FD, 9'h004, 9'h1FC, 9'h100};
  logic [80:0] kexp;

  conv_strip_scheduler #(.NUM_STRIPS(2), .STRIP_OUT_DEPTH(4), .ADDR_W(13), .DATA_W(23), .RD_LAT(2), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
    .frame_start(frame_start), .kernel_flat(kernel_flat), .kernel_read_complete(kernel_read_complete),
    .strip_rst(strip_rst), .strip_start(strip_start), .strip_done(strip_done), .strip_addr(strip_addr),
    .strip_out_flat(strip_out_flat), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // two-cycle read latency model of the strip output memories
  always @(posedge clk) begin
    p1 <= strip_addr;
    p2 <= p1;
  end
  assign strip_out_flat = {23'(200 + p2), 23'(100 + p2)};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_k(input logic [8:0] v);
    k_valid = 1;
    k_data  = v;
    step();
    k_valid = 0;
  endtask

  task automatic run_frame(input bit stall);
    int  got;
    int  cyc;
    bit  stalled;
    logic [31:0] e;
    got = 0;
    cyc = 0;
    stalled = 0;
    frame_start = 1;
    step();
    frame_start = 0;
    chk("clr_rst", strip_rst, 1);
    chk("clr_busy", busy, 1);
    step();
    chk("launch_start", strip_start, 1);
    chk("launch_rst", strip_rst, 0);
    k_valid = 1;
    k_data  = 9'h0AA;
    step();
    k_valid = 0;
    chk("wait_kready", k_ready, 0);
    repeat (3) step();
    strip_done = 2'b10;
    repeat (3) step();
    chk("no_pix_early", pix_valid, 0);
    strip_done = 2'b01;
    while (got < 8 && cyc < 400) begin
      step();
      cyc++;
      if (pix_valid) begin
        if (stall && !stalled && pix_data == 23'd102) begin
          pix_ready = 0;
          for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, 102);
            chk("stall_addr", strip_addr, 2);
          end
          pix_ready = 1;
          stalled = 1;
        end
        e = (got < 4 ? 100 : 200) + got % 4;
        chk("pix_data", pix_data, e);
        chk("pix_addr", strip_addr, got % 4);
        chk("pix_last", pix_last, got == 7);
        got++;
      end
    end
    chk("pix_count", got, 8);
    strip_done = 2'b00;
    step();
    chk("frame_done_pulse", frame_done, 1);
    chk("finish_pix_valid", pix_valid, 0);
    step();
    chk("frame_done_drop", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("kernel_kept", kernel_flat, kexp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int i = 0; i < 9; i++) kexp[i*9 +: 9] = kv[i];
    repeat (2) step();
    chk("rst_kready", k_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_kernel", kernel_flat, 0);
    chk("rst_krc", kernel_read_complete, 0);
    chk("rst_strip_rst", strip_rst, 1);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_addr", strip_addr, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 0;
    #1;
    chk("rel_strip_rst", strip_rst, 0);
    for (int i = 0; i < 5; i++) send_k(kv[i]);
    chk("partial_krc", kernel_read_complete, 0);
    frame_start = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      frame_start = 0;
      if (busy || strip_start) bad++;
    end
    chk("early_start_ignored", bad, 0);
    for (int i = 5; i < 9; i++) send_k(kv[i]);
    chk("krc_set", kernel_read_complete, 1);
    chk("k8_field", kernel_flat[80:72], 9'h100);
    chk("k0_field", kernel_flat[8:0], 9'h001);
    chk("kernel_all", kernel_flat, kexp);
    run_frame(0);
    run_frame(1);
    frame_start = 1;
    step();
    frame_start = 0;
    step();
    step();
    chk("abort_wait_rst", strip_rst, 0);
    reset = 1;
    #1;
    chk("abort_strip_rst", strip_rst, 1);
    step();
    chk("abort_busy", busy, 0);
    chk("abort_kready", k_ready, 1);
    chk("abort_krc", kernel_read_complete, 0);
    chk("abort_kernel", kernel_flat, 0);
    reset = 0;
    strip_done = 2'b11;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pix_valid || busy) bad++;
    end
    chk("abort_no_pix", bad, 0);
    strip_done = 2'b00;
    for (int i = 0; i < 9; i++) send_k(kv[i]);
    chk("reload_krc", kernel_read_complete, 1);
    run_frame(0);
`ifdef STRIP_TIMEOUT_EN
    begin
      int n;
      n = 0;
      bad = 0;
      frame_start = 1;
      step();
      frame_start = 0;
      step();
      step();
      while (!frame_done && n < 200) begin
        step();
        n++;
        if (pix_valid) bad++;
      end
      chk("to_cycles", n, 50);
      chk("to_err", timeout_err, 1);
      chk("to_no_pix", bad, 0);
      step();
      chk("to_idle", busy, 0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_strip_scheduler.md
Name: conv_strip_scheduler

Overview:
- Frame-level controller for the segmented-frame convolution path.
- Loads one 3x3 signed kernel from a coefficient stream and broadcasts it to NUM_STRIPS strip convolution units.
- Resets the units, launches them together and waits until every unit reports done.
- Then owns the shared strip read-address bus and drains each unit's output memory, strip 0 first, as one valid/ready pixel stream.

Parameters:
- NUM_STRIPS, 8, number of strip units (1..16).
- STRIP_OUT_DEPTH, 5772, results per strip (222 x 26).
- ADDR_W, 13, strip read-address width.
- DATA_W, 23, result width.
- RD_LAT, 2, cycles from address change to valid strip output (1..4).
- TIMEOUT_CYCLES, 2000000, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- k_valid  in  1  coefficient valid.
- k_data  in  9  signed coefficient, row-major k0..k8.
- k_ready  out  1  coefficient accepted when k_valid&k_ready.
- frame_start  in  1  request a frame.
- kernel_flat  out  81  k0 in [8:0] .. k8 in [80:72], to every unit.
- kernel_read_complete  out  1  all 9 coefficients loaded.
- strip_rst  out  1  reset to all units.
- strip_start  out  1  start to all units.
- strip_done  in  NUM_STRIPS  per-unit done (level).
- strip_addr  out  ADDR_W  shared read address.
- strip_out_flat  in  NUM_STRIPS*DATA_W  unit outputs; strip i at [i*DATA_W +: DATA_W].
- pix_data  out  DATA_W  result pixel.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  sink ready.
- pix_last  out  1  final pixel of frame.
- frame_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky watchdog error (0 when feature disabled).

Behaviour:
- Reset values:
  - State IDLE; k_ready=1; kernel_flat=0; kernel_read_complete=0.
  - strip_start=0; strip_addr=0; pix_valid=0; pix_last=0; frame_done=0; busy=0; timeout_err=0.
  - strip_rst = reset OR (state==CLR). Asserting reset mid-frame therefore also resets the units and abandons the frame; no partial pixels are emitted afterwards.
- Kernel load:
  - k_ready=1 only in IDLE. Each handshake writes k_data at index kidx, then increments kidx.
  - When kidx reaches 8 and that coefficient is accepted: kernel_read_complete<=1, kidx<=0.
  - A handshake while kernel_read_complete=1 clears it, writes index 0 and restarts the load.
  - k_valid outside IDLE is ignored.
- State machine:
  - IDLE: frame_start && kernel_read_complete && !k_valid -> CLR. frame_start without a complete kernel is ignored. k_valid wins over frame_start in the same cycle.
  - CLR: one cycle with strip_rst=1 -> LAUNCH.
  - LAUNCH: one cycle with strip_start=1; done_seen<=0 -> WAIT_DONE.
  - WAIT_DONE: done_seen <= done_seen | strip_done. When all bits are set -> RD_ISSUE with sidx=0, addr=0.
  - RD_ISSUE: drive strip_addr=addr; load wait counter with RD_LAT -> RD_WAIT.
  - RD_WAIT: decrement the counter. At 0, capture pix_data from strip sidx's slice -> RD_PRESENT.
  - RD_PRESENT: pix_valid=1. pix_data, pix_last and strip_addr are held stable until pix_ready. On handshake:
    - if addr==STRIP_OUT_DEPTH-1 and sidx==NUM_STRIPS-1 -> FINISH;
    - else if addr==STRIP_OUT_DEPTH-1: sidx+1, addr=0 -> RD_ISSUE;
    - else addr+1 -> RD_ISSUE.
  - FINISH: frame_done=1 for one cycle -> IDLE. kernel_flat is retained for the next frame.
- pix_last=1 only in RD_PRESENT for sidx=NUM_STRIPS-1 and addr=STRIP_OUT_DEPTH-1.
- Throughput: one pixel per RD_LAT+2 cycles when pix_ready is held high.
- kernel_flat is stable from CLR through FINISH.
- strip_done bits may arrive in any order or together; a bit that drops after being seen stays counted.

Optional Feature:
- Macro: STRIP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_DONE.
  - Reaching TIMEOUT_CYCLES sets timeout_err=1, pulses frame_done and returns to IDLE with no pixels emitted.
  - timeout_err clears only on reset or on the next CLR.
- Not defined: no counter; WAIT_DONE waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Reset, then load k0..k8 = 1,-1,2,-2,3,-3,4,-4,-256 -> kernel_read_complete=1 after the 9th handshake; kernel_flat[80:72]=9'h100, [8:0]=9'h001.
- frame_start with only 5 coefficients loaded -> stays IDLE, busy=0, strip_start never asserted.
- NUM_STRIPS=2, STRIP_OUT_DEPTH=4; model strips return 100+addr and 200+addr; done asserted in order strip1 then strip0 -> pixels 100,101,102,103,200,201,202,203; pix_last only on 203; frame_done one cycle after that handshake.
- Same setup with pix_ready low for 5 cycles on pixel 102 -> pix_data stays 102 and strip_addr stays 2 throughout; no pixel lost or duplicated.
- Reset asserted during WAIT_DONE -> strip_rst=1 that cycle, all outputs return to reset values, no pix_valid afterwards; a new load and frame complete normally.
- With STRIP_TIMEOUT_EN and TIMEOUT_CYCLES=50, strip_done held 0 -> timeout_err=1 and frame_done pulse exactly 50 cycles after WAIT_DONE entry, back in IDLE.
